bch_error_locate: RTL

- Stage directly downstream of bch_chien. Consumes the per-cycle term bus (T+1 terms of M bits) plus its first/valid/last strobes.
- Each valid cycle it XOR-reduces the terms. A zero sum marks a root, i.e. an error at the current bit position.
- The error flag is applied to the aligned data bit, giving a corrected bit stream.
- Counts located errors per codeword and reports a done/fail summary to the decoder controller.

---
 rtl/bch_error_locate.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/bch_error_locate.sv
// -----------------------------------------------------------------------------
// bch_error_locate
//
// Sits directly after bch_chien. Each valid cycle the T+1 Chien terms are
// XOR-reduced; a zero sum is a locator root, i.e. the bit currently being
// presented on data_in is in error. The error flag corrects the aligned data
// bit, and errors are counted per codeword. A done/fail summary goes to the
// decoder controller.
//
// Parameters
//   P         packed BCH parameter vector: M in bits [15:8], T in bits [7:0]
//   PIPELINE  0: one register stage after the reduction
//             1: extra register between the XOR tree and the zero compare
//
// Optional build macro
//   BCH_DEG_CHECK_EN  when defined, fail also asserts if the final error
//                     count differs from the sigma_deg latched at first.
//                     When undefined, sigma_deg is ignored entirely.
//
// Ports
//   clk, reset_n   clock (rising edge), asynchronous active-low reset
//   first          first valid chien cycle of a codeword
//   valid          chien bus and data_in valid this cycle
//   last           final valid chien cycle of a codeword
//   chien          T+1 terms, term i at [i*M +: M]
//   sigma_deg      locator degree, sampled with first
//   data_in        received bit aligned with the chien cycle
//   data_out       data_in XOR err_bit (latency 1+PIPELINE)
//   data_valid     data_out / err_bit valid
//   err_bit        error located at this position
//   done           one-cycle pulse with the last corrected bit
//   err_count      errors located in the codeword, held between dones
//   fail           uncorrectable indication, valid with done
//   fsm_state      debug view of the FSM (0 = IDLE, 1 = RUN)
//
// Stream semantics: valid-only, no backpressure. A cycle with valid=0 carries
// nothing; the pipeline still advances and emits data_valid=0, err_bit=0.
// -----------------------------------------------------------------------------
`ifndef BCH_M
`define BCH_M(p) ((((p) >> 8)) & 255)
`endif
`ifndef BCH_T
`define BCH_T(p) ((p) & 255)
`endif
`ifndef BCH_SIGMA_SZ
`define BCH_SIGMA_SZ(p) ((`BCH_T(p) + 1) * `BCH_M(p))
`endif
`ifndef BCH_SANE
`define BCH_SANE ((4 << 8) | 2)
`endif

module bch_error_locate #(
  parameter int P        = `BCH_SANE,
  parameter int PIPELINE = 0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               first,
  input  logic                               valid,
  input  logic                               last,
  input  logic [`BCH_SIGMA_SZ(P)-1:0]        chien,
  input  logic [$clog2(`BCH_T(P)+1):0]       sigma_deg,
  input  logic                               data_in,
  output logic                               data_out,
  output logic                               data_valid,
  output logic                               err_bit,
  output logic                               done,
  output logic [$clog2(`BCH_T(P)+1):0]       err_count,
  output logic                               fail,
  output logic                               fsm_state
);

  localparam int M  = `BCH_M(P);
  localparam int T  = `BCH_T(P);
  localparam int CW = $clog2(T + 1) + 1;
  localparam logic [CW-1:0] T_LIM   = CW'(T);
  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // XOR reduction of all terms; gated so an idle bus never looks like a root.
  logic [M-1:0] sum;
  always_comb begin
    sum = '0;
    if (valid) begin
      for (int i = 0; i <= T; i++) begin
        sum = sum ^ chien[i*M +: M];
      end
    end
  end

  // Stage feeding the compare/count logic: registered or direct.
  logic         s_valid;
  logic         s_first;
  logic         s_last;
  logic         s_data;
  logic [M-1:0] s_sum;
`ifdef BCH_DEG_CHECK_EN
  logic [CW-1:0] s_deg;
`endif

  generate
    if (PIPELINE != 0) begin : g_pipe
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s_valid <= 1'b0;
          s_first <= 1'b0;
          s_last  <= 1'b0;
          s_data  <= 1'b0;
          s_sum   <= '0;
`ifdef BCH_DEG_CHECK_EN
          s_deg   <= '0;
`endif
        end else begin
          s_valid <= valid;
          s_first <= first;
          s_last  <= last;
          s_data  <= data_in;
          s_sum   <= sum;
`ifdef BCH_DEG_CHECK_EN
          s_deg   <= sigma_deg;
`endif
        end
      end
    end else begin : g_direct
      assign s_valid = valid;
      assign s_first = first;
      assign s_last  = last;
      assign s_data  = data_in;
      assign s_sum   = sum;
`ifdef BCH_DEG_CHECK_EN
      assign s_deg   = sigma_deg;
`endif
    end
  endgenerate

`ifndef BCH_DEG_CHECK_EN
  logic unused_deg;
  assign unused_deg = ^sigma_deg;
`endif

  logic [CW-1:0] count_q;
`ifdef BCH_DEG_CHECK_EN
  logic [CW-1:0] deg_q;
`endif

  // in_cw: this stage cycle belongs to a codeword (a new first counts even
  // from RUN, which abandons the old codeword). Outside a codeword bits pass
  // through uncorrected.
  logic          start;
  logic          in_cw;
  logic          err;
  logic          end_cw;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_next;
  logic          fail_next;

  always_comb begin
    start    = s_valid & s_first;
    in_cw    = start | (s_valid & (state_q == RUN));
    err      = in_cw & (s_sum == '0);
    end_cw   = in_cw & s_last;
    cnt_base = start ? '0 : count_q;
    cnt_next = cnt_base;
    if (err && (cnt_base != CNT_MAX)) begin
      cnt_next = cnt_base + 1'b1;
    end
    fail_next = (cnt_next > T_LIM);
`ifdef BCH_DEG_CHECK_EN
    // Roots outside the shortened range leave count below the degree.
    if (cnt_next != (start ? s_deg : deg_q)) begin
      fail_next = 1'b1;
    end
`endif
  end

  // Next state. first&last together is a one-bit codeword: it passes through
  // RUN conceptually but the register never leaves IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start && !end_cw) state_d = RUN;
      RUN:  if (end_cw)           state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      data_out   <= 1'b0;
      data_valid <= 1'b0;
      err_bit    <= 1'b0;
      done       <= 1'b0;
      err_count  <= '0;
      fail       <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (in_cw) begin
        count_q <= cnt_next;
      end
      data_valid <= s_valid;
      err_bit    <= err;
      data_out   <= s_data ^ err;
      done       <= end_cw;
      if (end_cw) begin
        err_count <= cnt_next;
        fail      <= fail_next;
      end
    end
  end

`ifdef BCH_DEG_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deg_q <= '0;
    end else if (start) begin
      deg_q <= s_deg;
    end
  end
`endif

  assign fsm_state = state_q;

endmodule
